addsub_rr_scheduler: RTL and testbench
======================================

Name: addsub_rr_scheduler

Overview:
- Shares one N-bit ripple-carry add/subtract datapath between NUM_REQ requesters in the matrix-multiplication SoC.
- Each requester issues a/b operands and a sub flag over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle. The add/sub result is registered and returned on a single response channel, tagged with the requester ID.
- A wrapping transaction counter supports debug and performance monitoring.

Parameters:
- N, 16, operand/result width in bits.
- NUM_REQ, 4, number of requesters; fixed power of two, 2 to 8.
- ID_W, 2, requester ID width; must equal log2(NUM_REQ).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*N  operand A; requester i occupies bits [i*N +: N].
- req_b  input  NUM_REQ*N  operand B, same packing.
- req_sub  input  NUM_REQ  1 = A-B, 0 = A+B.
- rsp_valid  output  1  result register holds an undelivered result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that produced the result.
- rsp_result  output  N  sum/difference, modulo 2^N.
- rsp_carry  output  1  adder carry-out; for subtract, 1 = no borrow.
- rsp_overflow  output  1  two's-complement signed overflow.
- txn_count  output  16  accepted-transaction counter, wraps.

Behaviour:
- Reset (asynchronous, immediate): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_overflow=0, txn_count=0, last_grant=NUM_REQ-1. Requester 0 therefore has first priority after reset.
- accept_en = !rsp_valid | rsp_ready. This is combinational and allows full throughput: drain and refill in the same cycle.
- Arbitration (combinational):
  - Search req_valid starting at (last_grant+1) mod NUM_REQ, ascending with wrap. The first asserted index is gnt.
  - req_ready[gnt]=1 only if accept_en; all other bits are 0.
  - If no req_valid is asserted, req_ready=0.
- Handshake: transfer occurs when req_valid[i] & req_ready[i]. A requester holds valid, a, b and sub stable until accepted. Deasserting valid before acceptance is permitted and simply withdraws the request.
- Datapath, computed on the granted operands:
  - bx = b ^ {N{sub}}.
  - {carry, result} = a + bx + sub, with N+1-bit internal width.
  - overflow = (a[N-1] == bx[N-1]) & (result[N-1] != a[N-1]).
- On transfer, at the next clock edge:
  - Result register loads result/carry/overflow and rsp_id=gnt; rsp_valid=1.
  - last_grant=gnt.
  - txn_count increments; 0xFFFF wraps to 0x0000.
  - Latency is 1 cycle, request accept to rsp_valid.
- Response:
  - rsp_valid, rsp_id and rsp_result stay stable while rsp_valid & !rsp_ready.
  - If rsp_ready=1 and there is no new transfer, rsp_valid clears next cycle. Data fields hold their last value.
- Backpressure: while rsp_valid & !rsp_ready, all req_ready=0, last_grant is frozen and txn_count is frozen.
- Fairness: last_grant updates only on an actual transfer. A continuously requesting source waits at most NUM_REQ-1 transfers.
- Simultaneous events:
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - Drain and accept in the same cycle: new data replaces old and rsp_valid stays 1.
- Reset mid-operation: a pending response is discarded and the arbiter restarts at requester 0. Requesters must re-present any in-flight request.

Test Plan:
- Reset, then requester 0 only, a=0x0005, b=0x0003, sub=0, rsp_ready=1 -> req_ready=0001 in the same cycle. Next cycle: rsp_valid=1, rsp_id=0, rsp_result=0x0008, rsp_carry=0, rsp_overflow=0, txn_count=1.
- Requester 2: a=0x0003, b=0x0005, sub=1 -> rsp_result=0xFFFE, rsp_carry=0 (borrow), rsp_overflow=0. Then a=0x7FFF, b=0x0001, sub=0 -> rsp_result=0x8000, rsp_overflow=1, rsp_carry=0.
- All four requesters valid continuously, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3. One result per cycle; txn_count=8.
- rsp_ready=0 for 3 cycles with a response pending and all requests valid -> req_ready=0000 and the response fields hold steady. Then rsp_ready=1 -> the next grant goes to (last_grant+1) and one response is produced per cycle with no gap.
- Assert rst asynchronously mid-stream with rsp_valid=1 -> outputs clear immediately without waiting for a clock edge. After release with all requesters valid, the first grant is requester 0.
- Preload 0xFFFF transfers, then one more transfer -> txn_count wraps to 0x0000.

Source files
------------

// File: rtl/addsub_rr_scheduler.sv
// addsub_rr_scheduler: round-robin shared add/subtract unit with registered, ID-tagged response
module addsub_rr_scheduler #(
    parameter int N       = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [N-1:0]         rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_overflow,
    output logic [15:0]          txn_count
);
    logic [ID_W-1:0] r_last_grant;
    logic [ID_W-1:0] w_gnt;
    logic            w_found;
    logic            w_accept;
    logic            w_xfer;
    logic [N-1:0]    w_a;
    logic [N-1:0]    w_bx;
    logic            w_sub;
    logic [N:0]      w_sum;
    logic            w_ovf;

    // Wrap of the search index relies on NUM_REQ being a power of two.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_valid[r_last_grant + ID_W'(k)]) begin
                w_found = 1'b1;
                w_gnt   = r_last_grant + ID_W'(k);
            end
        end
    end

    assign w_accept  = !rsp_valid | rsp_ready;
    assign w_xfer    = w_found & w_accept;
    assign req_ready = w_xfer ? (NUM_REQ'(1) << w_gnt) : '0;

    assign w_sub = req_sub[w_gnt];
    assign w_a   = req_a[w_gnt*N +: N];
    assign w_bx  = req_b[w_gnt*N +: N] ^ {N{w_sub}};
    assign w_sum = {1'b0, w_a} + {1'b0, w_bx} + {{N{1'b0}}, w_sub};
    assign w_ovf = (w_a[N-1] == w_bx[N-1]) & (w_sum[N-1] != w_a[N-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            txn_count    <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (w_xfer) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= w_gnt;
            rsp_result   <= w_sum[N-1:0];
            rsp_carry    <= w_sum[N];
            rsp_overflow <= w_ovf;
            txn_count    <= txn_count + 16'd1;
            r_last_grant <= w_gnt;
        end else if (rsp_ready) begin
            rsp_valid    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// tb_addsub_rr_scheduler: directed bench for the round-robin add/sub scheduler
module tb_addsub_rr_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic [15:0] txn_count;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_res [4] = '{16'h0001, 16'h0100, 16'h0203, 16'h02FE};
    logic        exp_cy  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    addsub_rr_scheduler #(.N(16), .NUM_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_overflow(rsp_overflow), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_sub[i]        = s;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_txn", txn_count, 0);
        rst = 1'b0;
        // single requester 0: 5 + 3
        set_req(0, 16'h0005, 16'h0003, 1'b0);
        req_valid = 4'b0001;
        #1 chk("r0_ready", req_ready, 4'b0001);
        tick();
        chk("r0_valid", rsp_valid, 1);
        chk("r0_id", rsp_id, 0);
        chk("r0_result", rsp_result, 16'h0008);
        chk("r0_carry", rsp_carry, 0);
        chk("r0_ovf", rsp_overflow, 0);
        chk("r0_txn", txn_count, 1);
        // requester 2: 3 - 5 borrows
        set_req(2, 16'h0003, 16'h0005, 1'b1);
        req_valid = 4'b0100;
        #1 chk("r2_ready", req_ready, 4'b0100);
        tick();
        chk("r2sub_id", rsp_id, 2);
        chk("r2sub_result", rsp_result, 16'hFFFE);
        chk("r2sub_carry", rsp_carry, 0);
        chk("r2sub_ovf", rsp_overflow, 0);
        set_req(2, 16'h7FFF, 16'h0001, 1'b0);
        tick();
        chk("r2ovf_result", rsp_result, 16'h8000);
        chk("r2ovf_ovf", rsp_overflow, 1);
        chk("r2ovf_carry", rsp_carry, 0);
        chk("r2ovf_txn", txn_count, 3);
        req_valid = 4'b0000;
        tick();
        chk("drain_valid", rsp_valid, 0);
        chk("drain_hold", rsp_result, 16'h8000);
        chk("drain_txn", txn_count, 3);
        // all four requesters, full throughput rotation from reset
        rst = 1'b1; tick(); rst = 1'b0;
        set_req(0, 16'h0001, 16'h0000, 1'b0);
        set_req(1, 16'h0101, 16'h0001, 1'b1);
        set_req(2, 16'h0201, 16'h0002, 1'b0);
        set_req(3, 16'h0301, 16'h0003, 1'b1);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_ready", req_ready, 4'b0001 << (k % 4));
            tick();
            chk("rr_valid", rsp_valid, 1);
            chk("rr_id", rsp_id, k % 4);
            chk("rr_result", rsp_result, exp_res[k % 4]);
            chk("rr_carry", rsp_carry, exp_cy[k % 4]);
        end
        chk("rr_txn", txn_count, 8);
        // backpressure holds the id-3 response
        rsp_ready = 1'b0;
        #1 chk("bp_ready0", req_ready, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ready", req_ready, 4'b0000);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 3);
            chk("bp_result", rsp_result, 16'h02FE);
            chk("bp_txn", txn_count, 8);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_rel_ready", req_ready, 4'b0001);
        tick();
        chk("bp_rel_id0", rsp_id, 0);
        chk("bp_rel_txn9", txn_count, 9);
        chk("bp_rel_ready1", req_ready, 4'b0010);
        tick();
        chk("bp_rel_valid", rsp_valid, 1);
        chk("bp_rel_id1", rsp_id, 1);
        chk("bp_rel_txn10", txn_count, 10);
        // asynchronous reset between clock edges
        rst = 1'b1;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_id", rsp_id, 0);
        chk("arst_result", rsp_result, 0);
        chk("arst_txn", txn_count, 0);
        chk("arst_ready", req_ready, 4'b0001);
        rst = 1'b0;
        tick();
        chk("arst_first_id", rsp_id, 0);
        chk("arst_first_valid", rsp_valid, 1);
        chk("arst_first_txn", txn_count, 1);
        // counter wrap
        rst = 1'b1; #1 rst = 1'b0;
        req_valid = 4'b0001;
        repeat (65535) @(posedge clk);
        #1 chk("wrap_pre", txn_count, 16'hFFFF);
        tick();
        chk("wrap_post", txn_count, 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
